lru_tag_lookup: RTL and testbench

// - Set-associative tag lookup client that drives the per-set LRU tracker (lru_way).
// - Accepts lookup requests and compares tags; reports hit/miss.
// - On a hit, sends a touch to lru_way.
// - On an allocating miss, fills an invalid way or asks lru_way for a victim, then installs the new tag.
// - Sits between the NIC flow-table front end and lru_way; it is the initiator of the touch/victim protocol.

---
 rtl/lru_pkg.sv | 35 +++
 rtl/lru_tag_lookup_if.sv | 40 ++++
 rtl/lru_tag_ram.sv | 24 ++
 rtl/lru_tag_lookup.sv | 197 +++++++++++++++++++
 tb/tb_lru_tag_lookup.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lru_pkg.sv
// Shared types and helpers for the tag lookup client and the per-set LRU tracker.
// Geometry is fixed here so the entry and response structs have concrete widths.
package lru_pkg;

    localparam int unsigned NUM_SETS = 64;
    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned TAG_W    = 20;
    localparam int unsigned SET_W    = $clog2(NUM_SETS);
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {
        INIT, IDLE, READ, CMP, VREQ, VWAIT, INST, RESP
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] way;
        logic             evict;
        logic [TAG_W-1:0] evict_tag;
    } rsp_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [WAY_W-1:0] first_one(input logic [NUM_WAYS-1:0] vec);
        first_one = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) first_one = WAY_W'(i);
        end
    endfunction

endpackage

// File: rtl/lru_tag_lookup_if.sv
// Request/response bus plus the touch/victim channel toward lru_way.
// master = requester and LRU tracker side, slave = the lookup block.
interface lru_tag_lookup_if;

    logic                                     s_req_valid;
    logic                                     s_req_ready;
    logic [lru_pkg::SET_W+lru_pkg::TAG_W-1:0] s_req_addr;
    logic                                     s_req_alloc;
    logic                                     m_rsp_valid;
    logic                                     m_rsp_ready;
    logic                                     m_rsp_hit;
    logic [lru_pkg::WAY_W-1:0]                m_rsp_way;
    logic                                     m_rsp_evict;
    logic [lru_pkg::TAG_W-1:0]                m_rsp_evict_tag;
    logic                                     lru_touch_valid;
    logic [lru_pkg::SET_W-1:0]                lru_touch_set;
    logic [lru_pkg::WAY_W-1:0]                lru_touch_way;
    logic                                     lru_vict_valid;
    logic                                     lru_vict_ready;
    logic [lru_pkg::SET_W-1:0]                lru_vict_set;
    logic                                     lru_vict_rsp;
    logic [lru_pkg::WAY_W-1:0]                lru_vict_way;

    modport master (
        output s_req_valid, s_req_addr, s_req_alloc, m_rsp_ready,
               lru_vict_ready, lru_vict_rsp, lru_vict_way,
        input  s_req_ready, m_rsp_valid, m_rsp_hit, m_rsp_way, m_rsp_evict,
               m_rsp_evict_tag, lru_touch_valid, lru_touch_set, lru_touch_way,
               lru_vict_valid, lru_vict_set
    );

    modport slave (
        input  s_req_valid, s_req_addr, s_req_alloc, m_rsp_ready,
               lru_vict_ready, lru_vict_rsp, lru_vict_way,
        output s_req_ready, m_rsp_valid, m_rsp_hit, m_rsp_way, m_rsp_evict,
               m_rsp_evict_tag, lru_touch_valid, lru_touch_set, lru_touch_way,
               lru_vict_valid, lru_vict_set
    );

endinterface

// File: rtl/lru_tag_ram.sv
// Tag RAM: one row per set holding every way, per-way write enable, registered read.
module lru_tag_ram
    import lru_pkg::*;
(
    input  logic                          clk,
    input  logic [NUM_WAYS-1:0]           we,
    input  logic [SET_W-1:0]              waddr,
    input  tag_entry_t                    wdata,
    input  logic                          re,
    input  logic [SET_W-1:0]              raddr,
    output tag_entry_t [NUM_WAYS-1:0]     rdata
);

    tag_entry_t [NUM_WAYS-1:0] mem [NUM_SETS];

    // Storage is not reset; the lookup FSM clears every set after reset.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (we[w]) mem[waddr][w] <= wdata;
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/lru_tag_lookup.sv
// Set-associative tag lookup; reports hit/miss, installs on allocating misses
// and drives the touch/victim protocol of the per-set LRU tracker.
module lru_tag_lookup
    import lru_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    lru_tag_lookup_if.slave bus
);

    state_e           state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             alloc_q, alloc_d;
    logic             ready_q, ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    rsp_t             rsp_q, rsp_d;
    logic             touch_valid_q, touch_valid_d;
    logic [SET_W-1:0] touch_set_q, touch_set_d;
    logic [WAY_W-1:0] touch_way_q, touch_way_d;
    logic             vict_valid_q, vict_valid_d;
    logic [SET_W-1:0] vict_set_q, vict_set_d;

    logic [NUM_WAYS-1:0]       ram_we_c;
    logic [SET_W-1:0]          ram_waddr_c;
    tag_entry_t                ram_wdata_c;
    logic                      ram_re_c;
    tag_entry_t [NUM_WAYS-1:0] rd_data;
    logic [NUM_WAYS-1:0]       hit_vec_c, inv_vec_c;
    logic [WAY_W-1:0]          hit_way_c, inv_way_c;

    lru_tag_ram u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .re    (ram_re_c),
        .raddr (set_q),
        .rdata (rd_data)
    );

    // Per-way match and free-slot vectors from the row read for the current set.
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_c[w] = rd_data[w].valid && (rd_data[w].tag == tag_q);
            inv_vec_c[w] = !rd_data[w].valid;
        end
        hit_way_c = first_one(hit_vec_c);
        inv_way_c = first_one(inv_vec_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INIT;
            cnt_q         <= '0;
            set_q         <= '0;
            tag_q         <= '0;
            alloc_q       <= 1'b0;
            ready_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_q         <= '0;
            touch_valid_q <= 1'b0;
            touch_set_q   <= '0;
            touch_way_q   <= '0;
            vict_valid_q  <= 1'b0;
            vict_set_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            set_q         <= set_d;
            tag_q         <= tag_d;
            alloc_q       <= alloc_d;
            ready_q       <= ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_q         <= rsp_d;
            touch_valid_q <= touch_valid_d;
            touch_set_q   <= touch_set_d;
            touch_way_q   <= touch_way_d;
            vict_valid_q  <= vict_valid_d;
            vict_set_q    <= vict_set_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        set_d         = set_q;
        tag_d         = tag_q;
        alloc_d       = alloc_q;
        ready_d       = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_d         = rsp_q;
        touch_valid_d = 1'b0;
        touch_set_d   = touch_set_q;
        touch_way_d   = touch_way_q;
        vict_valid_d  = 1'b0;
        vict_set_d    = vict_set_q;
        ram_we_c      = '0;
        ram_waddr_c   = set_q;
        ram_wdata_c   = '0;
        ram_re_c      = 1'b0;

        case (state_q)
            INIT: begin
                ram_we_c    = '1;
                ram_waddr_c = cnt_q;
                cnt_d       = cnt_q + SET_W'(1);
                if (cnt_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                if (bus.s_req_valid && ready_q) begin
                    {tag_d, set_d} = bus.s_req_addr;
                    alloc_d        = bus.s_req_alloc;
                    ready_d        = 1'b0;
                    state_d        = READ;
                end
            end
            READ: begin
                ram_re_c = 1'b1;
                state_d  = CMP;
            end
            CMP: begin
                rsp_d = '0;
                if (|hit_vec_c) begin
                    rsp_d.hit     = 1'b1;
                    rsp_d.way     = hit_way_c;
                    touch_valid_d = 1'b1;
                    touch_set_d   = set_q;
                    touch_way_d   = hit_way_c;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (!alloc_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (|inv_vec_c) begin
                    rsp_d.way = inv_way_c;
                    state_d   = INST;
                end else begin
                    vict_valid_d = 1'b1;
                    vict_set_d   = set_q;
                    state_d      = VREQ;
                end
            end
            VREQ: begin
                vict_valid_d = 1'b1;
                if (vict_valid_q && bus.lru_vict_ready) begin
                    vict_valid_d = 1'b0;
                    state_d      = VWAIT;
                end
            end
            VWAIT: begin
                // Row read in READ is still held in the RAM output register.
                if (bus.lru_vict_rsp) begin
                    rsp_d.way       = bus.lru_vict_way;
                    rsp_d.evict     = 1'b1;
                    rsp_d.evict_tag = rd_data[bus.lru_vict_way].tag;
                    state_d         = INST;
                end
            end
            INST: begin
                ram_we_c      = NUM_WAYS'(1) << rsp_q.way;
                ram_wdata_c   = '{valid: 1'b1, tag: tag_q};
                touch_valid_d = 1'b1;
                touch_set_d   = set_q;
                touch_way_d   = rsp_q.way;
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (bus.m_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign bus.s_req_ready     = ready_q;
    assign bus.m_rsp_valid     = rsp_valid_q;
    assign bus.m_rsp_hit       = rsp_q.hit;
    assign bus.m_rsp_way       = rsp_q.way;
    assign bus.m_rsp_evict     = rsp_q.evict;
    assign bus.m_rsp_evict_tag = rsp_q.evict_tag;
    assign bus.lru_touch_valid = touch_valid_q;
    assign bus.lru_touch_set   = touch_set_q;
    assign bus.lru_touch_way   = touch_way_q;
    assign bus.lru_vict_valid  = vict_valid_q;
    assign bus.lru_vict_set    = vict_set_q;

endmodule

// File: tb/tb_lru_tag_lookup.sv
// Directed bench for lru_tag_lookup; the bench plays requester and lru_way.
module tb_lru_tag_lookup;
    import lru_pkg::*;

    localparam int unsigned RSP3_W = WAY_W + 2;
    localparam int unsigned TSW_W  = SET_W + WAY_W;

    typedef struct {
        int                lat;
        logic [RSP3_W-1:0] rsp3;   // {hit, way, evict}
        logic [TAG_W-1:0]  etag;
        logic              tv;
        logic [TSW_W-1:0]  tsw;    // {touch_set, touch_way}
        int                tdelta;
        int                vdelta;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lru_tag_lookup_if bus();
    lru_tag_lookup dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests  = 0;
    int n_fail   = 0;
    int touch_cnt = 0;
    int vict_cnt  = 0;

    always @(negedge clk) begin
        if (bus.lru_touch_valid === 1'b1) touch_cnt++;
        if (bus.lru_vict_valid === 1'b1) vict_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.s_req_ready, bus.m_rsp_valid, bus.m_rsp_hit, bus.m_rsp_way,
                    bus.m_rsp_evict, bus.m_rsp_evict_tag, bus.lru_touch_valid,
                    bus.lru_touch_set, bus.lru_touch_way, bus.lru_vict_valid,
                    bus.lru_vict_set});
    endfunction

    task automatic issue(input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set,
                         input logic alloc);
        bus.s_req_addr  = {tag, set};
        bus.s_req_alloc = alloc;
        bus.s_req_valid = 1'b1;
        tick();
        bus.s_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int i;
        i = 0;
        while (bus.m_rsp_valid !== 1'b1 && i < 40) begin
            tick();
            i++;
        end
        lat = (bus.m_rsp_valid === 1'b1) ? i : -1;
    endtask

    task automatic handshake();
        bus.m_rsp_ready = 1'b1;
        tick();
        bus.m_rsp_ready = 1'b0;
    endtask

    task automatic run_lookup(input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set,
                              input logic alloc, output obs_t o);
        int c0, v0;
        c0 = touch_cnt;
        v0 = vict_cnt;
        issue(tag, set, alloc);
        wait_rsp(o.lat);
        o.rsp3 = {bus.m_rsp_hit, bus.m_rsp_way, bus.m_rsp_evict};
        o.etag = bus.m_rsp_evict_tag;
        o.tv   = bus.lru_touch_valid;
        o.tsw  = {bus.lru_touch_set, bus.lru_touch_way};
        handshake();
        o.tdelta = touch_cnt - c0;
        o.vdelta = vict_cnt - v0;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        repeat (3) tick();
        n_tests++;
        if (all_outs() !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want 0", all_outs());
        end
        rst = 1'b0;
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (all_outs() !== 64'd0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL init_quiet: got %0d nonzero cycles want 0", bad);
        end
        tick();
        n_tests++;
        if (bus.s_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_ready: got %b want 1 after 64 cycles", bus.s_req_ready);
        end
    endtask

    task automatic test_miss_noalloc();
        obs_t o;
        run_lookup(20'h12345, 6'd5, 1'b0, o);
        n_tests++;
        if (o.lat !== 2 || o.rsp3 !== {1'b0, WAY_W'(0), 1'b0} || o.tv !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_noalloc: got lat=%0d rsp=%b tv=%b want lat=2 rsp=0000 tv=0",
                     o.lat, o.rsp3, o.tv);
        end
        n_tests++;
        if (o.tdelta !== 0 || o.vdelta !== 0) begin
            n_fail++;
            $display("FAIL miss_noalloc_side: got touches=%0d vict=%0d want 0/0", o.tdelta, o.vdelta);
        end
    endtask

    task automatic test_install();
        obs_t o;
        run_lookup(20'h12345, 6'd5, 1'b1, o);
        n_tests++;
        if (o.lat !== 3 || o.rsp3 !== {1'b0, WAY_W'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL install_rsp: got lat=%0d rsp=%b want lat=3 rsp=0000", o.lat, o.rsp3);
        end
        n_tests++;
        if (o.tv !== 1'b1 || o.tsw !== {SET_W'(5), WAY_W'(0)} || o.tdelta !== 1 || o.vdelta !== 0) begin
            n_fail++;
            $display("FAIL install_touch: got tv=%b tsw=%h n=%0d vict=%0d want 1 (5,0) 1 0",
                     o.tv, o.tsw, o.tdelta, o.vdelta);
        end
    endtask

    task automatic test_hit();
        obs_t o;
        run_lookup(20'h12345, 6'd5, 1'b0, o);
        n_tests++;
        if (o.lat !== 2 || o.rsp3 !== {1'b1, WAY_W'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL hit_rsp: got lat=%0d rsp=%b want lat=2 rsp=1000", o.lat, o.rsp3);
        end
        n_tests++;
        if (o.tv !== 1'b1 || o.tsw !== {SET_W'(5), WAY_W'(0)} || o.tdelta !== 1) begin
            n_fail++;
            $display("FAIL hit_touch: got tv=%b tsw=%h n=%0d want 1 (5,0) 1", o.tv, o.tsw, o.tdelta);
        end
        // One-bit tag difference and a different set must both miss.
        run_lookup(20'h12344, 6'd5, 1'b0, o);
        n_tests++;
        if (o.lat !== 2 || o.rsp3[RSP3_W-1] !== 1'b0 || o.tdelta !== 0) begin
            n_fail++;
            $display("FAIL near_tag_miss: got lat=%0d hit=%b n=%0d want 2 0 0",
                     o.lat, o.rsp3[RSP3_W-1], o.tdelta);
        end
        run_lookup(20'h12345, 6'd6, 1'b0, o);
        n_tests++;
        if (o.lat !== 2 || o.rsp3[RSP3_W-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL other_set_miss: got lat=%0d hit=%b want 2 0", o.lat, o.rsp3[RSP3_W-1]);
        end
    endtask

    task automatic test_fill();
        obs_t o;
        for (int i = 1; i <= 3; i++) begin
            run_lookup(TAG_W'(20'h00A00 + i), 6'd5, 1'b1, o);
            n_tests++;
            if (o.lat !== 3 || o.rsp3 !== {1'b0, WAY_W'(i), 1'b0} ||
                o.tsw !== {SET_W'(5), WAY_W'(i)}) begin
                n_fail++;
                $display("FAIL fill_way%0d: got lat=%0d rsp=%b tsw=%h want lat=3 way=%0d",
                         i, o.lat, o.rsp3, o.tsw, i);
            end
        end
    endtask

    task automatic test_victim();
        int i, bad, lat, c0;
        obs_t o;
        c0 = touch_cnt;
        issue(20'h00B00, 6'd5, 1'b1);
        i = 0;
        while (bus.lru_vict_valid !== 1'b1 && i < 20) begin
            tick();
            i++;
        end
        n_tests++;
        if (i !== 2 || bus.lru_vict_set !== SET_W'(5)) begin
            n_fail++;
            $display("FAIL vict_req: got cycles=%0d set=%0d want 2 5", i, bus.lru_vict_set);
        end
        bad = 0;
        repeat (3) begin
            tick();
            if (bus.lru_vict_valid !== 1'b1 || bus.lru_vict_set !== SET_W'(5) ||
                bus.m_rsp_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL vict_stall_hold: got %0d bad cycles want 0", bad);
        end
        bus.lru_vict_ready = 1'b1;
        tick();
        bus.lru_vict_ready = 1'b0;
        n_tests++;
        if (bus.lru_vict_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL vict_drop: got valid=%b want 0 after handshake", bus.lru_vict_valid);
        end
        tick();
        bus.lru_vict_rsp = 1'b1;
        bus.lru_vict_way = WAY_W'(2);
        tick();
        bus.lru_vict_rsp = 1'b0;
        bus.lru_vict_way = '0;
        wait_rsp(lat);
        n_tests++;
        if (lat !== 1 || {bus.m_rsp_hit, bus.m_rsp_way, bus.m_rsp_evict} !== {1'b0, WAY_W'(2), 1'b1} ||
            bus.m_rsp_evict_tag !== 20'h00A02) begin
            n_fail++;
            $display("FAIL vict_rsp: got lat=%0d hit=%b way=%0d ev=%b etag=%h want 1 0 2 1 00a02",
                     lat, bus.m_rsp_hit, bus.m_rsp_way, bus.m_rsp_evict, bus.m_rsp_evict_tag);
        end
        n_tests++;
        if (bus.lru_touch_valid !== 1'b1 || bus.lru_touch_set !== SET_W'(5) ||
            bus.lru_touch_way !== WAY_W'(2)) begin
            n_fail++;
            $display("FAIL vict_touch: got v=%b set=%0d way=%0d want 1 5 2",
                     bus.lru_touch_valid, bus.lru_touch_set, bus.lru_touch_way);
        end
        handshake();
        n_tests++;
        if (touch_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL vict_touch_count: got %0d want 1", touch_cnt - c0);
        end
        run_lookup(20'h00B00, 6'd5, 1'b0, o);
        n_tests++;
        if (o.rsp3 !== {1'b1, WAY_W'(2), 1'b0}) begin
            n_fail++;
            $display("FAIL new_tag_hit: got rsp=%b want 1100", o.rsp3);
        end
        run_lookup(20'h00A02, 6'd5, 1'b0, o);
        n_tests++;
        if (o.rsp3[RSP3_W-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL evicted_tag_miss: got hit=%b want 0", o.rsp3[RSP3_W-1]);
        end
    endtask

    task automatic test_back_to_back();
        int bad, lat, c0;
        logic [RSP3_W+TAG_W-1:0] snap;
        c0 = touch_cnt;
        issue(20'h12345, 6'd5, 1'b0);
        wait_rsp(lat);
        snap = {bus.m_rsp_hit, bus.m_rsp_way, bus.m_rsp_evict, bus.m_rsp_evict_tag};
        n_tests++;
        if (lat !== 2 || snap[RSP3_W+TAG_W-1 -: RSP3_W] !== {1'b1, WAY_W'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL stall_first: got lat=%0d rsp=%b want 2 1000", lat, snap[RSP3_W+TAG_W-1 -: RSP3_W]);
        end
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.m_rsp_valid !== 1'b1 || bus.s_req_ready !== 1'b0 || bus.lru_touch_valid !== 1'b0 ||
                {bus.m_rsp_hit, bus.m_rsp_way, bus.m_rsp_evict, bus.m_rsp_evict_tag} !== snap) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
        end
        handshake();
        n_tests++;
        if (touch_cnt - c0 !== 1 || bus.s_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_after: got touches=%0d ready=%b want 1 1", touch_cnt - c0, bus.s_req_ready);
        end
        // Next request goes in on the very first ready cycle.
        issue(20'h00A01, 6'd5, 1'b0);
        wait_rsp(lat);
        n_tests++;
        if (lat !== 2 || bus.m_rsp_hit !== 1'b1 || bus.m_rsp_way !== WAY_W'(1)) begin
            n_fail++;
            $display("FAIL b2b_hit: got lat=%0d hit=%b way=%0d want 2 1 1", lat, bus.m_rsp_hit, bus.m_rsp_way);
        end
        handshake();
    endtask

    task automatic test_reset_in_vwait();
        int i, bad, c0;
        obs_t o;
        issue(20'h00C00, 6'd5, 1'b1);
        bus.lru_vict_ready = 1'b1;
        i = 0;
        while (bus.lru_vict_valid !== 1'b1 && i < 20) begin
            tick();
            i++;
        end
        tick();
        bus.lru_vict_ready = 1'b0;
        n_tests++;
        if (i !== 2 || bus.lru_vict_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL vwait_entry: got cycles=%0d valid=%b want 2 0", i, bus.lru_vict_valid);
        end
        c0 = touch_cnt;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (all_outs() !== 64'd0) begin
            n_fail++;
            $display("FAIL vwait_reset_outs: got %h want 0", all_outs());
        end
        rst = 1'b0;
        bus.lru_vict_rsp = 1'b1;
        bus.lru_vict_way = WAY_W'(1);
        tick();
        bus.lru_vict_rsp = 1'b0;
        bus.lru_vict_way = '0;
        i = 1;
        bad = (bus.m_rsp_valid !== 1'b0 || bus.lru_touch_valid !== 1'b0) ? 1 : 0;
        while (bus.s_req_ready !== 1'b1 && i < 100) begin
            tick();
            i++;
            if (bus.m_rsp_valid !== 1'b0 || bus.lru_touch_valid !== 1'b0 || bus.lru_vict_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (i !== 64 || bad !== 0 || touch_cnt - c0 !== 0) begin
            n_fail++;
            $display("FAIL vwait_reinit: got cycles=%0d bad=%0d touches=%0d want 64 0 0",
                     i, bad, touch_cnt - c0);
        end
        run_lookup(20'h00B00, 6'd5, 1'b0, o);
        n_tests++;
        if (o.lat !== 2 || o.rsp3[RSP3_W-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL cleared_miss: got lat=%0d hit=%b want 2 0", o.lat, o.rsp3[RSP3_W-1]);
        end
    endtask

    initial begin
        bus.s_req_valid    = 1'b0;
        bus.s_req_addr     = '0;
        bus.s_req_alloc    = 1'b0;
        bus.m_rsp_ready    = 1'b0;
        bus.lru_vict_ready = 1'b0;
        bus.lru_vict_rsp   = 1'b0;
        bus.lru_vict_way   = '0;
        test_reset();
        test_miss_noalloc();
        test_install();
        test_hit();
        test_fill();
        test_victim();
        test_back_to_back();
        test_reset_in_vwait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
